fp_out_serializer: RTL and testbench
====================================

FP_OUT_SERIALIZER -- requirements
Module: fp_out_serializer

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 1: 1 sends result bits [63:56] first; 0 sends bits [7:0] first.
REQ-002 The block SHALL have parameter QUIET_NAN, default 0: 1 forces frac[51]=1 on any NaN word (expn all ones, frac nonzero) at push time.
REQ-003 The block SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port RESET  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port RES_VALID  input  1  one-cycle strobe; the result word is present this cycle.
REQ-006 The block SHALL have port RES_SIGN  input  1  result sign.
REQ-007 The block SHALL have port RES_EXPN  input  11  result biased exponent.
REQ-008 The block SHALL have port RES_FRAC  input  52  result fraction.
REQ-009 The block SHALL have port HOLD  input  1  consumer stall; 1 freezes the current byte.
REQ-010 The block SHALL have port DATA_OUT  output  8  current output byte.
REQ-011 The block SHALL have port READY  output  1  DATA_OUT is valid this cycle.
REQ-012 The block SHALL have port IN_FULL  output  1  registered; FIFO holds 2 words.
REQ-013 The block SHALL have port OVERFLOW  output  1  sticky; a push was dropped.

Function
REQ-014 The block SHALL pack each word as {RES_SIGN, RES_EXPN, RES_FRAC} = 64 bits, in IEEE-754 double layout.
REQ-015 The block SHALL buffer words in a 2-entry FIFO with a registered count of 0..2.
REQ-016 The block SHALL accept a push iff RES_VALID=1 and the registered count<2, with no same-cycle pop credit.
REQ-017 The block SHALL drop RES_VALID while count==2 and set OVERFLOW=1 until reset; FIFO contents stay unchanged.
REQ-018 The block SHALL update count as count + push - pop; simultaneous push and pop leaves count unchanged and keeps order.
REQ-019 The block SHALL implement output FSM states IDLE and SEND, together with a 64-bit shift register and a 3-bit byte counter.
REQ-020 In IDLE with count>0, the block SHALL pop the head into the shift register, set the byte counter to 0 and move to SEND on the same edge.
REQ-021 A word pushed into an empty FIFO in IDLE SHALL NOT be visible for pop until the following cycle.
REQ-022 In SEND, READY SHALL be 1 and DATA_OUT SHALL be the byte selected by the byte counter, in MSB_FIRST order.
REQ-023 In SEND with HOLD=1, DATA_OUT, READY and the byte counter SHALL hold.
REQ-024 In SEND with HOLD=0 and counter<7, the byte counter SHALL increment.
REQ-025 In SEND with HOLD=0, counter==7 and count>0, the block SHALL pop the next word, reset the counter to 0 and stay in SEND, with no gap cycle.
REQ-026 In SEND with HOLD=0, counter==7 and count==0, the block SHALL move to IDLE.
REQ-027 In IDLE, READY SHALL be 0 and DATA_OUT SHALL be 8'h00.
REQ-028 Latency SHALL be 2 edges: a push at edge k into an empty idle block gives READY=1 from edge k+1, with byte 0 visible before edge k+2.
REQ-029 One word SHALL occupy exactly 8 non-HOLD SEND cycles.
REQ-030 HOLD SHALL be ignored in IDLE.

Reset
REQ-031 RESET=0 SHALL asynchronously force FSM=IDLE, count=0, byte counter=0, READY=0, DATA_OUT=8'h00, IN_FULL=0 and OVERFLOW=0.
REQ-032 Reset mid-frame SHALL abort the frame; FIFO contents are discarded and no partial bytes are emitted after release.
REQ-033 After RESET deasserts, the first push SHALL be accepted on the next rising edge.

Verification
REQ-034 Push 0x3FF0000000000000 (1.0), HOLD=0, MSB_FIRST=1 -> READY high 8 cycles, DATA_OUT = 3F,F0,00,00,00,00,00,00, then READY=0.
REQ-035 Two pushes on consecutive cycles, 0x4000000000000000 then 0xC008000000000000 -> 16 contiguous READY cycles: 40,00x7 then C0,08,00x6, with no gap.
REQ-036 Three pushes while byte 0 of the first word is held (HOLD=1) -> third push dropped, OVERFLOW=1 and sticky, first two words emitted intact.
REQ-037 HOLD=1 for 3 cycles at byte 2 of 0x0123456789ABCDEF -> DATA_OUT=45 held 4 cycles total; sequence otherwise unchanged.
REQ-038 With QUIET_NAN=1, push 0x7FF0000000000001 -> bytes 7F,F8,00,00,00,00,00,01.
REQ-039 RESET low during byte 4 of a frame with 1 word queued -> READY=0 and DATA_OUT=00 immediately; after release, no output until a new push.

Source files
------------

// File: rtl/fp_out_serializer.sv
// Serialises 64-bit IEEE-754 double results into a byte stream through a
// 2-entry FIFO. HOLD stalls the stream; a push into a full FIFO is dropped and flagged.
module fp_out_serializer #(
  parameter bit MSB_FIRST = 1'b1,
  parameter bit QUIET_NAN = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RES_VALID,
  input  logic        RES_SIGN,
  input  logic [10:0] RES_EXPN,
  input  logic [51:0] RES_FRAC,
  input  logic        HOLD,
  output logic [7:0]  DATA_OUT,
  output logic        READY,
  output logic        IN_FULL,
  output logic        OVERFLOW
);

  localparam int unsigned WORD_W = 64;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned BCNT_W = 3;

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                ready_q, ready_d;
  logic                in_full_q, in_full_d;
  logic                overflow_q, overflow_d;

  logic                push_c;
  logic                pop_c;
  logic                full_c;
  logic [51:0]         frac_c;
  logic [WORD_W-1:0]   word_c;

  // Incoming word, optionally quietened when it is a NaN
  always_comb begin
    frac_c = RES_FRAC;
    if (QUIET_NAN && (&RES_EXPN) && (|RES_FRAC)) frac_c[51] = 1'b1;
    word_c = {RES_SIGN, RES_EXPN, frac_c};
  end

  assign full_c = (count_q == CNT_W'(DEPTH));
  assign push_c = RES_VALID && !full_c;

  // Next-state: output FSM, FIFO bookkeeping and registered outputs
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bcnt_d     = bcnt_q;
    pop_c      = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ready_d    = 1'b0;
    data_d     = '0;
    in_full_d  = 1'b0;
    overflow_d = overflow_q;

    unique case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop_c   = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
          bcnt_d  = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!HOLD) begin
          if (bcnt_q != BCNT_W'(7)) begin
            bcnt_d  = bcnt_q + BCNT_W'(1);
            shreg_d = MSB_FIRST ? {shreg_q[WORD_W-BYTE_W-1:0], BYTE_W'(0)}
                                : {BYTE_W'(0), shreg_q[WORD_W-1:BYTE_W]};
          end else if (count_q != '0) begin
            pop_c   = 1'b1;
            shreg_d = mem_q[rd_ptr_q];
            bcnt_d  = '0;
          end else begin
            bcnt_d  = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (push_c) wr_ptr_d = ~wr_ptr_q;
    if (pop_c)  rd_ptr_d = ~rd_ptr_q;
    count_d = CNT_W'(count_q + CNT_W'(push_c) - CNT_W'(pop_c));

    // The shift register always presents the current byte at its output end
    ready_d = (state_d == ST_SEND);
    if (ready_d) data_d = MSB_FIRST ? shreg_d[WORD_W-1 -: BYTE_W] : shreg_d[BYTE_W-1:0];
    in_full_d  = (count_d == CNT_W'(DEPTH));
    overflow_d = overflow_q | (RES_VALID & full_c);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      shreg_q    <= '0;
      bcnt_q     <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      in_full_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (push_c) mem_q[wr_ptr_q] <= word_c;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shreg_q    <= shreg_d;
      bcnt_q     <= bcnt_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      in_full_q  <= in_full_d;
      overflow_q <= overflow_d;
    end
  end

  assign DATA_OUT = data_q;
  assign READY    = ready_q;
  assign IN_FULL  = in_full_q;
  assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_fp_out_serializer.sv
// Directed bench for fp_out_serializer: framing, back-to-back words, HOLD,
// overflow, NaN quietening, byte order and mid-frame reset.
module tb_fp_out_serializer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        RES_VALID;
  logic        RES_SIGN;
  logic [10:0] RES_EXPN;
  logic [51:0] RES_FRAC;
  logic        HOLD;

  logic [7:0]  data_out, data_out_q, data_out_l;
  logic        ready, ready_q, ready_l;
  logic        in_full, in_full_q, in_full_l;
  logic        overflow, overflow_q, overflow_l;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  fp_out_serializer dut (
    .CLK(CLK), .RESET(RESET), .RES_VALID(RES_VALID), .RES_SIGN(RES_SIGN),
    .RES_EXPN(RES_EXPN), .RES_FRAC(RES_FRAC), .HOLD(HOLD),
    .DATA_OUT(data_out), .READY(ready), .IN_FULL(in_full), .OVERFLOW(overflow)
  );

  fp_out_serializer #(.MSB_FIRST(1'b1), .QUIET_NAN(1'b1)) dut_qnan (
    .CLK(CLK), .RESET(RESET), .RES_VALID(RES_VALID), .RES_SIGN(RES_SIGN),
    .RES_EXPN(RES_EXPN), .RES_FRAC(RES_FRAC), .HOLD(HOLD),
    .DATA_OUT(data_out_q), .READY(ready_q), .IN_FULL(in_full_q), .OVERFLOW(overflow_q)
  );

  fp_out_serializer #(.MSB_FIRST(1'b0), .QUIET_NAN(1'b0)) dut_lsb (
    .CLK(CLK), .RESET(RESET), .RES_VALID(RES_VALID), .RES_SIGN(RES_SIGN),
    .RES_EXPN(RES_EXPN), .RES_FRAC(RES_FRAC), .HOLD(HOLD),
    .DATA_OUT(data_out_l), .READY(ready_l), .IN_FULL(in_full_l), .OVERFLOW(overflow_l)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] w);
    RES_VALID = v;
    RES_SIGN  = w[63];
    RES_EXPN  = w[62:52];
    RES_FRAC  = w[51:0];
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    step();
    step();
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  // Eight contiguous MSB-first bytes of w on the default instance
  task automatic expect_word(input string tag, input logic [63:0] w);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_rdy"}, 64'(ready), 64'd1);
      check({tag, "_byte"}, 64'(data_out), 64'(w[63-8*i -: 8]));
      step();
    end
  endtask

  logic [7:0] one_bytes  [8] = '{8'h3F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] qnan_bytes [8] = '{8'h7F, 8'hF8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
  logic [7:0] snan_bytes [8] = '{8'h7F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
  logic [7:0] lsb_bytes  [8] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h7F};
  logic [7:0] hold_bytes [11] = '{8'h01, 8'h23, 8'h45, 8'h45, 8'h45, 8'h45,
                                  8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

  initial begin
    RESET = 1'b0;
    HOLD  = 1'b0;
    drive(1'b0, 64'h0);
    step();
    step();
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_data", 64'(data_out), 64'h00);
    check("rst_full", 64'(in_full), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    @(negedge CLK);
    RESET = 1'b1;

    // Single word 1.0, with 2-edge latency
    drive(1'b1, 64'h3FF0000000000000);
    step();
    drive(1'b0, 64'h0);
    check("lat_ready0", 64'(ready), 64'd0);
    step();
    for (int i = 0; i < 8; i++) begin
      check("one_rdy", 64'(ready), 64'd1);
      check("one_byte", 64'(data_out), 64'(one_bytes[i]));
      step();
    end
    check("one_end", 64'(ready), 64'd0);
    check("one_end_data", 64'(data_out), 64'h00);

    // Back-to-back words with no gap
    drive(1'b1, 64'h4000000000000000);
    step();
    drive(1'b1, 64'hC008000000000000);
    step();
    drive(1'b0, 64'h0);
    expect_word("b2b_a", 64'h4000000000000000);
    expect_word("b2b_b", 64'hC008000000000000);
    check("b2b_end", 64'(ready), 64'd0);

    // Overflow while byte 0 is held
    drive(1'b1, 64'h3FF0000000000000);
    step();
    drive(1'b0, 64'h0);
    step();
    HOLD = 1'b1;
    drive(1'b1, 64'h4000000000000000);
    step();
    drive(1'b1, 64'hC008000000000000);
    step();
    check("ovf_pre", 64'(overflow), 64'd0);
    drive(1'b1, 64'h1122334455667788);
    step();
    drive(1'b0, 64'h0);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_full", 64'(in_full), 64'd1);
    check("ovf_held", 64'(data_out), 64'h3F);
    step();
    HOLD = 1'b0;
    expect_word("ovf_a", 64'h3FF0000000000000);
    expect_word("ovf_b", 64'h4000000000000000);
    expect_word("ovf_c", 64'hC008000000000000);
    check("ovf_end", 64'(ready), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("ovf_notfull", 64'(in_full), 64'd0);
    do_reset();
    check("ovf_cleared", 64'(overflow), 64'd0);

    // HOLD for 3 cycles on byte 2
    drive(1'b1, 64'h0123456789ABCDEF);
    step();
    drive(1'b0, 64'h0);
    step();
    for (int i = 0; i < 11; i++) begin
      HOLD = (i >= 2 && i <= 4);
      check("hold_rdy", 64'(ready), 64'd1);
      check("hold_byte", 64'(data_out), 64'(hold_bytes[i]));
      step();
    end
    HOLD = 1'b0;
    check("hold_end", 64'(ready), 64'd0);

    // NaN: quietened, raw, and LSB-first orderings
    drive(1'b1, 64'h7FF0000000000001);
    step();
    drive(1'b0, 64'h0);
    step();
    for (int i = 0; i < 8; i++) begin
      check("qnan_byte", 64'(data_out_q), 64'(qnan_bytes[i]));
      check("snan_byte", 64'(data_out), 64'(snan_bytes[i]));
      check("lsb_byte", 64'(data_out_l), 64'(lsb_bytes[i]));
      check("lsb_rdy", 64'(ready_l), 64'd1);
      step();
    end
    check("nan_end", 64'(ready_q), 64'd0);

    // Reset during byte 4 with one word queued
    drive(1'b1, 64'h0123456789ABCDEF);
    step();
    drive(1'b1, 64'hC008000000000000);
    step();
    drive(1'b0, 64'h0);
    step();
    step();
    step();
    step();
    check("mid_byte4", 64'(data_out), 64'h89);
    RESET = 1'b0;
    #1;
    check("mid_rst_ready", 64'(ready), 64'd0);
    check("mid_rst_data", 64'(data_out), 64'h00);
    step();
    @(negedge CLK);
    RESET = 1'b1;
    HOLD = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("post_rst_idle", 64'(ready), 64'd0);
      step();
    end

    // First push after reset, HOLD asserted while idle
    @(negedge CLK);
    drive(1'b1, 64'h4000000000000000);
    step();
    drive(1'b0, 64'h0);
    step();
    HOLD = 1'b0;
    expect_word("post_rst", 64'h4000000000000000);
    for (int i = 0; i < 4; i++) begin
      check("post_rst_end", 64'(ready), 64'd0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
